// File: rtl/aes_stager_pkg.sv
// rtl/aes_stager_pkg.sv - register map, bit indices, FSM encoding and defaults for the AES block stager
package aes_stager_pkg;

   // Register offsets (adr[7:0])
   localparam logic [7:0] OFF_KEY_BASE  = 8'h00;
   localparam logic [7:0] OFF_DATA_BASE = 8'h10;
   localparam logic [7:0] OFF_CTRL      = 8'h20;
   localparam logic [7:0] OFF_STATUS    = 8'h24;
   localparam logic [7:0] OFF_RES_BASE  = 8'h30;
   localparam logic [7:0] OFF_RES3      = 8'h3C;

   // CTRL bit indices
   localparam int CTRL_START   = 0;
   localparam int CTRL_DECRYPT = 1;
   localparam int CTRL_IRQEN   = 2;

   // STATUS bit indices
   localparam int STAT_BUSY = 0;
   localparam int STAT_DONE = 1;
   localparam int STAT_OVR  = 2;
   localparam int STAT_ERR  = 3;

   // Defaults
   localparam logic [31:0] DEF_BASE_ADR = 32'h3000_0000;
   localparam logic [15:0] DEF_TIMEOUT  = 16'd1023;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } stager_state_t;

endpackage

// File: rtl/aes_wb_block_stager_if.sv
// rtl/aes_wb_block_stager_if.sv - Wishbone slave bus plus AES core handshake bundle
interface aes_wb_block_stager_if;
   logic         wbs_cyc_i;
   logic         wbs_stb_i;
   logic         wbs_we_i;
   logic [3:0]   wbs_sel_i;
   logic [31:0]  wbs_adr_i;
   logic [31:0]  wbs_dat_i;
   logic         wbs_ack_o;
   logic [31:0]  wbs_dat_o;
   logic         blk_valid_o;
   logic         blk_ready_i;
   logic [127:0] blk_data_o;
   logic [127:0] key_o;
   logic         decrypt_o;
   logic         res_valid_i;
   logic [127:0] res_data_i;
   logic         irq_o;

   // The stager itself
   modport slave (
      input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      input  blk_ready_i, res_valid_i, res_data_i,
      output wbs_ack_o, wbs_dat_o, blk_valid_o, blk_data_o, key_o, decrypt_o, irq_o
   );

   // The SoC bus master together with the AES core
   modport master (
      output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      output blk_ready_i, res_valid_i, res_data_i,
      input  wbs_ack_o, wbs_dat_o, blk_valid_o, blk_data_o, key_o, decrypt_o, irq_o
   );
endinterface

// File: rtl/aes_stager_wordbank.sv
// rtl/aes_stager_wordbank.sv - 4x32 register bank with per-byte write enable and write lock
module aes_stager_wordbank (
   input  logic         clk,
   input  logic         rst,
   input  logic         we,
   input  logic         lock,
   input  logic [1:0]   idx,
   input  logic [3:0]   sel,
   input  logic [31:0]  wdata,
   output logic [127:0] q
);

   // Byte-granular word update; lock drops writes while the block is in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         q <= '0;
      end else if (we && !lock) begin
         for (int b = 0; b < 4; b++) begin
            if (sel[b]) begin
               q[32*int'(idx) + 8*b +: 8] <= wdata[8*b +: 8];
            end
         end
      end
   end

endmodule

// File: rtl/aes_wb_block_stager.sv
// rtl/aes_wb_block_stager.sv - Wishbone key/data stager for an AES core; optional irq via AES_STAGER_IRQ_EN
module aes_wb_block_stager
   import aes_stager_pkg::*;
#(
   parameter logic [31:0] BASE_ADR = DEF_BASE_ADR,
   parameter logic [15:0] TIMEOUT  = DEF_TIMEOUT
) (
   input  logic                   wb_clk_i,
   input  logic                   wb_rst_i,
   aes_wb_block_stager_if.slave   bus
);

   stager_state_t state, state_nxt;

   logic         ack_q;
   logic [31:0]  dat_q;
   logic [31:0]  rdata;
   logic [127:0] key_q;
   logic [127:0] data_q;
   logic [127:0] res_q;
   logic [15:0]  wait_cnt;
   logic         done_q, ovr_q, err_q, decrypt_q;
   logic         irqen;
   logic         blk_valid;

   // A new request is only taken when no ack is outstanding, which spaces acks at least 2 cycles apart
   logic       wb_hit, wb_req, wb_wr, wb_rd, busy;
   logic [7:0] off;
   logic       key_we, data_we, ctrl_wr, start_wr, res3_rd, res_take, tmo;

   assign wb_hit   = (bus.wbs_adr_i[31:8] == BASE_ADR[31:8]);
   assign wb_req   = bus.wbs_cyc_i && bus.wbs_stb_i && !ack_q && wb_hit;
   assign wb_wr    = wb_req && bus.wbs_we_i;
   assign wb_rd    = wb_req && !bus.wbs_we_i;
   assign off      = bus.wbs_adr_i[7:0];
   assign busy     = (state != ST_IDLE);

   assign key_we   = wb_wr && (off[7:4] == OFF_KEY_BASE[7:4])  && (off[1:0] == 2'b00);
   assign data_we  = wb_wr && (off[7:4] == OFF_DATA_BASE[7:4]) && (off[1:0] == 2'b00);
   assign ctrl_wr  = wb_wr && (off == OFF_CTRL) && bus.wbs_sel_i[0];
   assign start_wr = ctrl_wr && bus.wbs_dat_i[CTRL_START];
   assign res3_rd  = wb_rd && (off == OFF_RES3);

   // A result arriving on the last wait cycle beats the timeout
   assign res_take = (state == ST_WAIT) && bus.res_valid_i;
   assign tmo      = (state == ST_WAIT) && !bus.res_valid_i && (wait_cnt == TIMEOUT - 16'd1);

   aes_stager_wordbank u_key_bank (
      .clk   (wb_clk_i),
      .rst   (wb_rst_i),
      .we    (key_we),
      .lock  (busy),
      .idx   (off[3:2]),
      .sel   (bus.wbs_sel_i),
      .wdata (bus.wbs_dat_i),
      .q     (key_q)
   );

   aes_stager_wordbank u_data_bank (
      .clk   (wb_clk_i),
      .rst   (wb_rst_i),
      .we    (data_we),
      .lock  (busy),
      .idx   (off[3:2]),
      .sel   (bus.wbs_sel_i),
      .wdata (bus.wbs_dat_i),
      .q     (data_q)
   );

   // FSM state register
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) state <= ST_IDLE;
      else          state <= state_nxt;
   end

   // FSM next state and block-valid output
   always_comb begin
      state_nxt = state;
      blk_valid = 1'b0;
      case (state)
         ST_IDLE:  if (start_wr) state_nxt = ST_ISSUE;
         ST_ISSUE: begin
            blk_valid = 1'b1;
            if (bus.blk_ready_i) state_nxt = ST_WAIT;
         end
         ST_WAIT:  if (res_take || tmo) state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // Result-wait cycle counter, restarted every time WAIT is entered
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i || state != ST_WAIT) wait_cnt <= '0;
      else                              wait_cnt <= wait_cnt + 16'd1;
   end

   // Status flags, DECRYPT control and result capture
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         done_q    <= 1'b0;
         ovr_q     <= 1'b0;
         err_q     <= 1'b0;
         decrypt_q <= 1'b0;
         res_q     <= '0;
      end else begin
         if (start_wr) begin
            if (busy) begin
               ovr_q <= 1'b1;
            end else begin
               done_q <= 1'b0;
               err_q  <= 1'b0;
               ovr_q  <= 1'b0;
            end
         end
         if (ctrl_wr && !busy) decrypt_q <= bus.wbs_dat_i[CTRL_DECRYPT];
         if (res3_rd) done_q <= 1'b0;
         if (res_take) begin
            done_q <= 1'b1;
            res_q  <= bus.res_data_i;
         end
         if (tmo) err_q <= 1'b1;
      end
   end

`ifdef AES_STAGER_IRQ_EN
   // Interrupt mask bit, writable at any time
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i)     irqen <= 1'b0;
      else if (ctrl_wr) irqen <= bus.wbs_dat_i[CTRL_IRQEN];
   end
   assign bus.irq_o = irqen && (done_q || err_q);
`else
   assign irqen     = 1'b0;
   assign bus.irq_o = 1'b0;
`endif

   // Read data mux; anything not decoded reads zero
   always_comb begin
      rdata = '0;
      if (off[1:0] == 2'b00) begin
         case (off[7:4])
            OFF_KEY_BASE[7:4]:  rdata = key_q[32*int'(off[3:2]) +: 32];
            OFF_DATA_BASE[7:4]: rdata = data_q[32*int'(off[3:2]) +: 32];
            OFF_CTRL[7:4]: begin
               if (off == OFF_CTRL) begin
                  rdata[CTRL_DECRYPT] = decrypt_q;
                  rdata[CTRL_IRQEN]   = irqen;
               end else if (off == OFF_STATUS) begin
                  rdata[STAT_BUSY] = busy;
                  rdata[STAT_DONE] = done_q;
                  rdata[STAT_OVR]  = ovr_q;
                  rdata[STAT_ERR]  = err_q;
               end
            end
            OFF_RES_BASE[7:4]:  rdata = res_q[32*int'(off[3:2]) +: 32];
            default:            rdata = '0;
         endcase
      end
   end

   // Registered ack pulse and read data
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         ack_q <= 1'b0;
         dat_q <= '0;
      end else begin
         ack_q <= wb_req;
         dat_q <= wb_rd ? rdata : 32'h0;
      end
   end

   assign bus.wbs_ack_o   = ack_q;
   assign bus.wbs_dat_o   = dat_q;
   assign bus.blk_valid_o = blk_valid;
   assign bus.key_o       = key_q;
   assign bus.blk_data_o  = data_q;
   assign bus.decrypt_o   = decrypt_q;

endmodule

// File: tb/tb_aes_wb_block_stager.sv
// tb/tb_aes_wb_block_stager.sv - scoreboard bench for aes_wb_block_stager; honours AES_STAGER_IRQ_EN
module tb_aes_wb_block_stager;
   import aes_stager_pkg::*;

   localparam logic [31:0] BASE = 32'h3000_0000;
   localparam int          TMO  = 1023;

`ifdef AES_STAGER_IRQ_EN
   localparam logic [31:0] IRQ_BIT = 32'h4;
   localparam logic        IRQ_ON  = 1'b1;
`else
   localparam logic [31:0] IRQ_BIT = 32'h0;
   localparam logic        IRQ_ON  = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   aes_wb_block_stager_if bus ();

   aes_wb_block_stager dut (
      .wb_clk_i (clk),
      .wb_rst_i (rst),
      .bus      (bus)
   );

   typedef struct {
      string        tag;
      logic [127:0] v;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   logic [127:0] m_key, m_data, res_a, res_b;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic sb_push(input string tag, input logic [127:0] v);
      exp_t e;
      e.tag = tag;
      e.v   = v;
      sb.push_back(e);
   endtask

   task automatic sb_pop_chk(input logic [127:0] got);
      exp_t e;
      if (sb.size() == 0) begin
         chk("sb_underflow", 128'd1, 128'd0);
      end else begin
         e = sb.pop_front();
         chk(e.tag, got, e.v);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wb_xfer(input logic we, input logic [7:0] off, input logic [31:0] d,
                          input logic [3:0] sel, output logic [31:0] rd);
      bit got_ack = 0;
      bus.wbs_cyc_i = 1'b1;
      bus.wbs_stb_i = 1'b1;
      bus.wbs_we_i  = we;
      bus.wbs_adr_i = BASE | {24'h0, off};
      bus.wbs_dat_i = d;
      bus.wbs_sel_i = sel;
      rd = '0;
      for (int i = 0; i < 8 && !got_ack; i++) begin
         cyc(1);
         if (bus.wbs_ack_o) begin
            got_ack = 1;
            rd = bus.wbs_dat_o;
         end
      end
      bus.wbs_cyc_i = 1'b0;
      bus.wbs_stb_i = 1'b0;
      bus.wbs_we_i  = 1'b0;
      if (!got_ack) chk("wb_ack_timeout", 128'd0, 128'd1);
   endtask

   task automatic wb_write(input logic [7:0] off, input logic [31:0] d, input logic [3:0] sel);
      logic [31:0] dummy;
      wb_xfer(1'b1, off, d, sel, dummy);
   endtask

   task automatic wb_read_exp(input string tag, input logic [7:0] off, input logic [31:0] exp);
      logic [31:0] rd;
      sb_push(tag, {96'h0, exp});
      wb_xfer(1'b0, off, 32'h0, 4'hf, rd);
      sb_pop_chk({96'h0, rd});
   endtask

   task automatic start_op(input logic [31:0] ctrl);
      sb_push("issue_key", m_key);
      sb_push("issue_data", m_data);
      sb_push("issue_decrypt", {127'h0, ctrl[1]});
      wb_write(OFF_CTRL, ctrl, 4'hf);
   endtask

   task automatic wait_valid();
      bit seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         if (bus.blk_valid_o) seen = 1;
         else cyc(1);
      end
      if (!seen) begin
         chk("blk_valid_timeout", 128'd0, 128'd1);
         sb.delete();
      end else begin
         sb_pop_chk(bus.key_o);
         sb_pop_chk(bus.blk_data_o);
         sb_pop_chk({127'h0, bus.decrypt_o});
      end
   endtask

   task automatic pulse_result(input logic [127:0] r);
      bus.res_data_i  = r;
      bus.res_valid_i = 1'b1;
      cyc(1);
      bus.res_valid_i = 1'b0;
   endtask

   task automatic chk_res(input string tag, input logic [127:0] r);
      for (int i = 0; i < 4; i++)
         wb_read_exp(tag, OFF_RES_BASE + 8'(4*i), r[32*i +: 32]);
   endtask

   initial begin
      bit ok;
      bus.wbs_cyc_i   = 1'b0;
      bus.wbs_stb_i   = 1'b0;
      bus.wbs_we_i    = 1'b0;
      bus.wbs_sel_i   = 4'h0;
      bus.wbs_adr_i   = '0;
      bus.wbs_dat_i   = '0;
      bus.blk_ready_i = 1'b0;
      bus.res_valid_i = 1'b0;
      bus.res_data_i  = '0;
      m_key  = 128'h000102030405060708090a0b0c0d0e0f;
      m_data = 128'h00112233445566778899aabbccddeeff;
      res_a  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
      res_b  = {$urandom, $urandom, $urandom, $urandom};

      // Reset state
      cyc(3);
      rst = 1'b0;
      cyc(1);
      chk("rst_blk_valid", {127'h0, bus.blk_valid_o}, 128'd0);
      chk("rst_irq", {127'h0, bus.irq_o}, 128'd0);
      chk("rst_ack", {127'h0, bus.wbs_ack_o}, 128'd0);
      wb_read_exp("rst_status", OFF_STATUS, 32'h0);
      wb_read_exp("rst_key0", OFF_KEY_BASE, 32'h0);

      // Test 1: basic encrypt round trip
      for (int i = 0; i < 4; i++) begin
         wb_write(OFF_KEY_BASE + 8'(4*i), m_key[32*i +: 32], 4'hf);
         wb_write(OFF_DATA_BASE + 8'(4*i), m_data[32*i +: 32], 4'hf);
      end
      wb_read_exp("t1_key3", 8'h0C, 32'h00010203);
      wb_read_exp("t1_undecoded", 8'h40, 32'h0);
      bus.blk_ready_i = 1'b1;
      start_op(32'h1 | IRQ_BIT);
      wait_valid();
      cyc(1);
      chk("t1_valid_drop", {127'h0, bus.blk_valid_o}, 128'd0);
      pulse_result(res_a);
      wb_read_exp("t1_status", OFF_STATUS, 32'h2);
      wb_read_exp("t1_res0", 8'h30, 32'h70b4c55a);
      chk("t6_irq_done", {127'h0, bus.irq_o}, {127'h0, IRQ_ON});
      wb_read_exp("t1_res3", 8'h3C, 32'h69c4e0d8);
      chk("t6_irq_clear", {127'h0, bus.irq_o}, 128'd0);
      wb_read_exp("t1_status_after", OFF_STATUS, 32'h0);

      // Test 3: byte selects, then dropped while busy
      wb_write(OFF_DATA_BASE, 32'h11223344, 4'hf);
      wb_write(OFF_DATA_BASE, 32'hAABBCCDD, 4'b0101);
      m_data[31:0] = 32'h11BB33DD;
      wb_read_exp("t3_sel", OFF_DATA_BASE, 32'h11BB33DD);

      // Test 2: core stalls, overrun, no second issue
      bus.blk_ready_i = 1'b0;
      start_op(32'h3 | IRQ_BIT);
      wait_valid();
      ok = 1;
      for (int i = 0; i < 20; i++) begin
         cyc(1);
         if (!bus.blk_valid_o || bus.key_o !== m_key || bus.blk_data_o !== m_data) ok = 0;
      end
      chk("t2_hold_stable", {127'h0, ok}, 128'd1);
      wb_read_exp("t2_status_busy", OFF_STATUS, 32'h1);
      wb_write(OFF_DATA_BASE, 32'h55667788, 4'b0101);
      wb_read_exp("t3_locked", OFF_DATA_BASE, 32'h11BB33DD);
      wb_write(OFF_CTRL, 32'h1 | IRQ_BIT, 4'hf);
      wb_read_exp("t2_status_ovr", OFF_STATUS, 32'h5);
      chk("t2_decrypt_held", {127'h0, bus.decrypt_o}, 128'd1);
      bus.blk_ready_i = 1'b1;
      cyc(1);
      bus.blk_ready_i = 1'b0;
      chk("t2_valid_drop", {127'h0, bus.blk_valid_o}, 128'd0);
      pulse_result(res_b);
      ok = 1;
      for (int i = 0; i < 10; i++) begin
         if (bus.blk_valid_o) ok = 0;
         cyc(1);
      end
      chk("t2_no_reissue", {127'h0, ok}, 128'd1);
      wb_read_exp("t2_status_done", OFF_STATUS, 32'h6);
      wb_read_exp("t2_ctrl", OFF_CTRL, 32'h2 | IRQ_BIT);
      chk_res("t2_res", res_b);
      wb_read_exp("t2_status_final", OFF_STATUS, 32'h4);

      // Test 4: timeout, late result ignored
      bus.blk_ready_i = 1'b1;
      start_op(32'h1);
      wait_valid();
      cyc(1);
      cyc(TMO - 20);
      wb_read_exp("t4_still_busy", OFF_STATUS, 32'h1);
      cyc(40);
      wb_read_exp("t4_status_err", OFF_STATUS, 32'h8);
      pulse_result(~res_b);
      chk_res("t4_res_kept", res_b);

      // Test 5: reset while waiting
      start_op(32'h1);
      wait_valid();
      cyc(3);
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
      chk("t5_blk_valid", {127'h0, bus.blk_valid_o}, 128'd0);
      chk("t5_key", bus.key_o, 128'd0);
      chk("t5_data", bus.blk_data_o, 128'd0);
      chk("t5_irq", {127'h0, bus.irq_o}, 128'd0);
      pulse_result(res_a);
      wb_read_exp("t5_status", OFF_STATUS, 32'h0);
      wb_read_exp("t5_ctrl", OFF_CTRL, 32'h0);
      chk_res("t5_res", 128'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule
